fft_frame_sequencer: RTL
========================

// Module: fft_frame_sequencer
// PURPOSE
//  Sequences the 32-word FFT sample register bank, which has a single write port and
//  latches all 32 words in parallel.
//  Accepts a valid/ready stream of samples from the RS5 core, writes them to
//  consecutive addresses, then issues one parallel-read (snapshot) cycle.
//  Then pulses start to the FFT engine, waits for its done, and holds a
//  frame-ready flag until software acknowledges.
// PARAMETERS
//  N_SAMPLES  32  words per frame; power of two, >= 2
//  AW         $clog2(N_SAMPLES)  RAM address width (derived, do not override)
// PORTS
//  clk            in   1     system clock; all logic on posedge
//  rst            in   1     reset, asynchronous, active-high
//  s_valid_i      in   1     sample valid
//  s_ready_o      out  1     sample ready
//  s_data_i       in   32    sample word; low 16 bits are used by the RAM
//  clear_i        in   1     synchronous frame abort
//  ack_i          in   1     software acknowledge of a finished frame
//  ram_en_o       out  1     RAM enable
//  ram_we_o       out  1     RAM write enable (0 with en=1 = snapshot read)
//  ram_addr_o     out  AW    RAM write address
//  ram_data_o     out  32    RAM write data
//  fft_start_o    out  1     one-cycle FFT start pulse
//  fft_done_i     in   1     FFT completion (level or pulse)
//  busy_o         out  1     1 in SNAP/START/WAIT
//  frame_ready_o  out  1     1 in DONE
//  count_o        out  AW+1  samples accepted in the current frame (0..N_SAMPLES)
// BEHAVIOUR
//  Reset values:
//   - state=LOAD, count=0.
//   - All ram_* outputs 0; fft_start_o=0, busy_o=0, frame_ready_o=0.
//   - s_ready_o=1 one cycle after rst deasserts.
//  FSM states: LOAD, SNAP, START, WAIT, DONE.
//  LOAD:
//   - s_ready_o=1.
//   - Handshake = s_valid_i & s_ready_o in cycle t.
//   - Cycle t+1 (registered outputs): ram_en_o=1, ram_we_o=1,
//     ram_addr_o=count(t), ram_data_o=s_data_i(t).
//   - count increments on each handshake.
//   - The handshake that makes count==N_SAMPLES moves LOAD->SNAP; s_ready_o drops next cycle.
//   - ram_en_o=0 in every cycle without a pending write.
//  SNAP:
//   - Exactly one cycle with ram_en_o=1, ram_we_o=0, ram_addr_o=0.
//   - Occurs after the last write cycle has completed.
//   - Then -> START.
//  START: fft_start_o=1 for exactly one cycle -> WAIT. fft_done_i is ignored in START.
//  WAIT: stay until fft_done_i=1 -> DONE. fft_done_i is ignored in every other state.
//  DONE:
//   - frame_ready_o=1; count_o holds N_SAMPLES.
//   - ack_i=1 -> LOAD with count=0.
//   - ack_i outside DONE is ignored.
//  clear_i:
//   - Highest priority over ack, done and handshake.
//   - Next cycle: state=LOAD, count=0; ram_en_o, fft_start_o and frame_ready_o are 0.
//   - A sample offered in the same cycle as clear_i is dropped.
//  Reset mid-frame: asynchronous return to reset values; RAM contents are left as-is.
//  count_o never wraps; ram_addr_o wraps only through the frame restart.
// CONFIGURATION
//  FFT_SEQ_IRQ_EN defined:
//   - Adds port irq_o (out, 1), registered.
//   - irq_o is set on the WAIT->DONE transition.
//   - Cleared by ack_i, clear_i or rst; reset value 0.
//  FFT_SEQ_IRQ_EN undefined: no irq_o port; software polls frame_ready_o.
// STRUCTURE
//  RS5_pkg additions:
//   - typedef enum logic [2:0] fft_seq_state_e {LOAD, SNAP, START, WAIT, DONE}.
//   - localparam int FFT_N_SAMPLES = 32.
//  Single module; no sub-module (counter and FSM inline).
// TESTING
//  1. rst high 3 cycles, then low:
//     all outputs 0 during reset; s_ready_o=1 the next cycle; count_o=0.
//  2. 32 back-to-back samples 0x0000..0x001F:
//     - writes to addr 0..31, each one cycle after its handshake;
//     - one snapshot cycle (en=1, we=0);
//     - fft_start_o pulse exactly 1 cycle;
//     - busy_o=1 until done.
//  3. fft_done_i pulsed 10 cycles after start, then ack_i 5 cycles later:
//     frame_ready_o=1 for exactly those 5 cycles; then count_o=0 and s_ready_o=1.
//  4. Valid toggled every other cycle with random data:
//     exactly 32 writes; ram_addr_o is monotonic 0..31; no write while valid=0.
//  5. clear_i at count_o=17 with s_valid_i=1:
//     next cycle count_o=0, no RAM write for that sample; the next frame restarts at addr 0.
//  6. fft_done_i high in LOAD and START, and ack_i high in WAIT:
//     all ignored; with FFT_SEQ_IRQ_EN, irq_o rises only at WAIT->DONE.

Source files
------------

// File: rtl/fft_frame_sequencer_pkg.sv
// fft_frame_sequencer_pkg: shared state encoding and frame size for the FFT sample sequencer.
package fft_frame_sequencer_pkg;
    localparam int FFT_N_SAMPLES = 32;
    typedef enum logic [2:0] {LOAD, SNAP, START, WAIT, DONE} fft_seq_state_e;
endpackage

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads a frame into the FFT sample bank, snapshots it, starts the FFT and holds frame-ready until ack.
// Optional FFT_SEQ_IRQ_EN adds a registered irq_o raised when the FFT finishes.
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int N_SAMPLES = FFT_N_SAMPLES,
    localparam int AW = $clog2(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [31:0]   s_data_i,
    input  logic          clear_i,
    input  logic          ack_i,
    output logic          ram_en_o,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [31:0]   ram_data_o,
    output logic          fft_start_o,
    input  logic          fft_done_i,
`ifdef FFT_SEQ_IRQ_EN
    output logic          irq_o,
`endif
    output logic          busy_o,
    output logic          frame_ready_o,
    output logic [AW:0]   count_o
);
    localparam logic [AW:0] LAST = (AW+1)'(N_SAMPLES - 1);
    fft_seq_state_e state, next;
    logic [AW:0] count;
    logic hs;
    assign hs = s_valid_i & s_ready_o & ~clear_i;
    assign busy_o = (state == SNAP) || (state == START) || (state == WAIT);
    assign frame_ready_o = state == DONE;
    assign count_o = count;
    always_comb begin
        next = state;
        case (state)
            LOAD:    next = (hs && count == LAST) ? SNAP : LOAD;
            SNAP:    next = START;
            START:   next = WAIT;
            WAIT:    next = fft_done_i ? DONE : WAIT;
            DONE:    next = ack_i ? LOAD : DONE;
            default: next = LOAD;
        endcase
        if (clear_i) next = LOAD;
    end
    // RAM strobes and start are registered, so the bank sees write -> snapshot -> start in strict order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            count       <= '0;
            s_ready_o   <= 1'b0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            fft_start_o <= 1'b0;
        end else begin
            state       <= next;
            s_ready_o   <= next == LOAD;
            count       <= clear_i ? '0 : hs ? count + 1'b1 : (state == DONE && ack_i) ? '0 : count;
            ram_en_o    <= hs | (state == SNAP && !clear_i);
            ram_we_o    <= hs;
            ram_addr_o  <= hs ? count[AW-1:0] : '0;
            ram_data_o  <= hs ? s_data_i : '0;
            fft_start_o <= state == START && !clear_i;
        end
    end
`ifdef FFT_SEQ_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_o <= 1'b0;
        else irq_o <= clear_i ? 1'b0 : (state == WAIT && fft_done_i) ? 1'b1 : (state == DONE && ack_i) ? 1'b0 : irq_o;
    end
`endif
endmodule
